// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational 8-bit ALU through an IDLE/EXEC/RESP handshake FSM.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; fixed priority (req0 first) otherwise.
module alu_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [1:0] req0_sel,
  input  logic [1:0] req0_shift,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [1:0] req1_sel,
  input  logic [1:0] req1_shift,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_result,
  output logic       rsp0_c,
  output logic       rsp0_z,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_result,
  output logic       rsp1_c,
  output logic       rsp1_z,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_sel,
  output logic [1:0] alu_shift,
  input  logic [7:0] alu_result,
  input  logic       alu_cout,
  input  logic       alu_zout,
  output logic       busy
);

  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 2;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_next;
  logic            owner, owner_next;
  logic [DW-1:0]   alu_a_next, alu_b_next;
  logic [OPW-1:0]  alu_sel_next, alu_shift_next;
  logic            cap0, cap1;
  logic            grant;
  logic            any_valid;
  logic            accept;
  logic            rsp_take;

`ifdef ALU_ARB_RR_EN
  logic            last_grant;
`endif

  // Grant selection; only meaningful while at least one request is valid.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      grant = ~last_grant;
`else
      grant = 1'b0;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign any_valid  = req0_valid | req1_valid;
  assign req0_ready = (state == IDLE) && any_valid && !grant && !rst;
  assign req1_ready = (state == IDLE) && any_valid &&  grant && !rst;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign rsp_take   = owner ? rsp1_ready : rsp0_ready;

  // Next-state and datapath load decisions.
  always_comb begin
    state_next     = state;
    owner_next     = owner;
    alu_a_next     = alu_a;
    alu_b_next     = alu_b;
    alu_sel_next   = alu_sel;
    alu_shift_next = alu_shift;
    cap0           = 1'b0;
    cap1           = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next     = EXEC;
          owner_next     = grant;
          alu_a_next     = grant ? req1_a     : req0_a;
          alu_b_next     = grant ? req1_b     : req0_b;
          alu_sel_next   = grant ? req1_sel   : req0_sel;
          alu_shift_next = grant ? req1_shift : req0_shift;
        end
      end
      EXEC: begin
        state_next = RESP;
        cap0       = !owner;
        cap1       = owner;
      end
      RESP: begin
        if (rsp_take) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      alu_shift   <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_c      <= 1'b0;
      rsp0_z      <= 1'b0;
      rsp1_result <= '0;
      rsp1_c      <= 1'b0;
      rsp1_z      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      alu_a      <= alu_a_next;
      alu_b      <= alu_b_next;
      alu_sel    <= alu_sel_next;
      alu_shift  <= alu_shift_next;
      rsp0_valid <= (state_next == RESP) && !owner_next;
      rsp1_valid <= (state_next == RESP) &&  owner_next;
      busy       <= (state_next != IDLE);
      if (cap0) begin
        rsp0_result <= alu_result;
        rsp0_c      <= alu_cout;
        rsp0_z      <= alu_zout;
      end
      if (cap1) begin
        rsp1_result <= alu_result;
        rsp1_c      <= alu_cout;
        rsp1_z      <= alu_zout;
      end
    end
  end

`ifdef ALU_ARB_RR_EN
  // Last-grant pointer; reset to 1 so req0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= grant;
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed ops push expected responses, a monitor pops and compares.
// Grant expectations follow ALU_ARB_RR_EN when it is defined for the build.
module tb_alu_arbiter;

`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] sel;
    logic [1:0] shift;
    logic [7:0] res;
    logic       c;
    logic       z;
  } op_t;

  typedef struct {
    logic       owner;
    logic [7:0] res;
    logic       c;
    logic       z;
  } exp_t;

  logic       clk, rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_sel, req0_shift, req1_sel, req1_shift;
  logic       rsp0_valid, rsp0_ready, rsp0_c, rsp0_z;
  logic       rsp1_valid, rsp1_ready, rsp1_c, rsp1_z;
  logic [7:0] rsp0_result, rsp1_result;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_sel, alu_shift;
  logic       alu_cout, alu_zout, busy;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  op_t  q0[$];
  op_t  q1[$];
  bit   ptr;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel), .req0_shift(req0_shift),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel), .req1_shift(req1_shift),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_c(rsp0_c), .rsp0_z(rsp0_z),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_c(rsp1_c), .rsp1_z(rsp1_z),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_shift(alu_shift),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zout(alu_zout),
    .busy(busy)
  );

  // ALU stub: 8-bit add with carry and zero flags.
  assign {alu_cout, alu_result} = 9'(alu_a) + 9'(alu_b);
  assign alu_zout = (alu_result == 8'h00);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input logic n, input logic [7:0] res, input logic c, input logic z);
    exp_t e;
    if (sb.size() == 0) begin
      chk("rsp_unexpected", 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      chk("rsp_owner",  32'(n),      32'(e.owner));
      chk("rsp_result", 32'(res),    32'(e.res));
      chk("rsp_flags",  32'({c, z}), 32'({e.c, e.z}));
    end
  endtask

  // Monitor: compares every completed response handshake against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp0_valid || rsp1_valid) chk("rsp_exclusive", 32'(rsp0_valid & rsp1_valid), 32'(0));
      if (rsp0_valid && rsp0_ready) pop_chk(1'b0, rsp0_result, rsp0_c, rsp0_z);
      if (rsp1_valid && rsp1_ready) pop_chk(1'b1, rsp1_result, rsp1_c, rsp1_z);
    end
  end

  task automatic set_req(input bit n, input op_t op, input logic v);
    if (!n) begin
      req0_valid = v; req0_a = op.a; req0_b = op.b; req0_sel = op.sel; req0_shift = op.shift;
    end else begin
      req1_valid = v; req1_a = op.a; req1_b = op.b; req1_sel = op.sel; req1_shift = op.shift;
    end
  endtask

  function automatic exp_t mk_exp(input bit n, input op_t op);
    exp_t e;
    e.owner = n; e.res = op.res; e.c = op.c; e.z = op.z;
    return e;
  endfunction

  // One op on a lone requester with latency and EXEC-field checks.
  task automatic single_op(input bit n, input op_t op);
    set_req(n, op, 1'b1);
    @(negedge clk);
    chk("rdy_first", 32'(n ? req1_ready : req0_ready), 32'(1));
    chk("rdy_other", 32'(n ? req0_ready : req1_ready), 32'(0));
    sb.push_back(mk_exp(n, op));
    ptr = n;
    @(posedge clk); #1;
    set_req(n, op, 1'b0);
    @(negedge clk);
    chk("exec_busy",  32'(busy),      32'(1));
    chk("exec_a",     32'(alu_a),     32'(op.a));
    chk("exec_b",     32'(alu_b),     32'(op.b));
    chk("exec_ctl",   32'({alu_sel, alu_shift}), 32'({op.sel, op.shift}));
    chk("exec_norsp", 32'({rsp0_valid, rsp1_valid}), 32'(0));
    @(negedge clk);
    chk("rsp_own_valid",   32'(n ? rsp1_valid : rsp0_valid), 32'(1));
    chk("rsp_other_valid", 32'(n ? rsp0_valid : rsp1_valid), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic drive_fronts();
    op_t z = '{default: '0};
    if (q0.size() != 0) set_req(1'b0, q0[0], 1'b1); else set_req(1'b0, z, 1'b0);
    if (q1.size() != 0) set_req(1'b1, q1[0], 1'b1); else set_req(1'b1, z, 1'b0);
  endtask

  // Drains the request queues, checking each grant against the arbitration model.
  task automatic run_ops(input int budget);
    int cyc = 0;
    bit g;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0 || busy) && cyc < budget) begin
      drive_fronts();
      @(negedge clk);
      if (busy) begin
        chk("busy_rdy", 32'({req0_ready, req1_ready}), 32'(0));
      end else if (req0_valid || req1_valid) begin
        if (req0_valid && req1_valid) g = RR ? ~ptr : 1'b0;
        else                          g = req1_valid;
        chk("grant", 32'({req1_ready, req0_ready}), g ? 32'(2) : 32'(1));
        if (req0_valid && req0_ready) begin
          sb.push_back(mk_exp(1'b0, q0.pop_front())); ptr = 1'b0;
        end else if (req1_valid && req1_ready) begin
          sb.push_back(mk_exp(1'b1, q1.pop_front())); ptr = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("run_timeout", 32'(cyc < budget), 32'(1));
    drive_fronts();
  endtask

  initial begin
    op_t t1, t2, f, s, t, u, r, nop;
    int  w;
    nop = '{default: '0};
    t1  = '{a: 8'h05, b: 8'h03, sel: 2'b00, shift: 2'b00, res: 8'h08, c: 1'b0, z: 1'b0};
    t2  = '{a: 8'hFF, b: 8'h01, sel: 2'b01, shift: 2'b00, res: 8'h00, c: 1'b1, z: 1'b1};
    f   = '{a: 8'h0A, b: 8'h0B, sel: 2'b10, shift: 2'b01, res: 8'h15, c: 1'b0, z: 1'b0};
    s   = '{a: 8'h20, b: 8'h30, sel: 2'b00, shift: 2'b00, res: 8'h50, c: 1'b0, z: 1'b0};
    t   = '{a: 8'hC8, b: 8'h64, sel: 2'b11, shift: 2'b10, res: 8'h2C, c: 1'b1, z: 1'b0};
    u   = '{a: 8'h01, b: 8'h02, sel: 2'b00, shift: 2'b11, res: 8'h03, c: 1'b0, z: 1'b0};
    r   = '{a: 8'h10, b: 8'h22, sel: 2'b01, shift: 2'b01, res: 8'h32, c: 1'b0, z: 1'b0};

    rst = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req(1'b0, nop, 1'b0);
    set_req(1'b1, nop, 1'b0);
    ptr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    set_req(1'b0, t1, 1'b1);
    @(negedge clk);
    chk("rst_busy",    32'(busy), 32'(0));
    chk("rst_rspv",    32'({rsp0_valid, rsp1_valid}), 32'(0));
    chk("rst_alu",     32'({alu_a, alu_b, alu_sel, alu_shift}), 32'(0));
    chk("rst_rsp0",    32'({rsp0_result, rsp0_c, rsp0_z}), 32'(0));
    chk("rst_rsp1",    32'({rsp1_result, rsp1_c, rsp1_z}), 32'(0));
    chk("rst_rdy",     32'({req0_ready, req1_ready}), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    single_op(1'b0, t1);
    single_op(1'b1, t2);

    // Three back-to-back ties, then the leftover request.
    q0.push_back('{a: 8'h11, b: 8'h22, sel: 2'b00, shift: 2'b00, res: 8'h33, c: 1'b0, z: 1'b0});
    q0.push_back('{a: 8'h80, b: 8'h80, sel: 2'b01, shift: 2'b01, res: 8'h00, c: 1'b1, z: 1'b1});
    q0.push_back('{a: 8'h7F, b: 8'h01, sel: 2'b10, shift: 2'b10, res: 8'h80, c: 1'b0, z: 1'b0});
    q1.push_back('{a: 8'hF0, b: 8'h20, sel: 2'b11, shift: 2'b11, res: 8'h10, c: 1'b1, z: 1'b0});
    run_ops(200);

    single_op(1'b0, f);

    // Response stall with both requesters waiting.
    set_req(1'b0, s, 1'b1);
    @(negedge clk);
    chk("stall_rdy", 32'(req0_ready), 32'(1));
    sb.push_back(mk_exp(1'b0, s));
    ptr = 1'b0;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    set_req(1'b0, u, 1'b1);
    set_req(1'b1, t, 1'b1);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!rsp0_valid && w < 6);
    chk("stall_reach", 32'(rsp0_valid), 32'(1));
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      chk("stall_valid",  32'({rsp0_valid, rsp1_valid}), 32'(2));
      chk("stall_result", 32'({rsp0_result, rsp0_c, rsp0_z}), 32'({s.res, s.c, s.z}));
      chk("stall_rdy0",   32'({req0_ready, req1_ready}), 32'(0));
      chk("stall_busy",   32'(busy), 32'(1));
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    q0.push_back(u);
    q1.push_back(t);
    run_ops(200);

    // Reset mid-EXEC discards the op.
    set_req(1'b0, r, 1'b1);
    @(negedge clk);
    chk("rr_rdy", 32'(req0_ready), 32'(1));
    @(posedge clk); #1;
    set_req(1'b0, r, 1'b0);
    @(negedge clk);
    chk("rr_exec", 32'({busy, alu_a}), 32'({1'b1, 8'h10}));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ptr = 1'b1;
    @(negedge clk);
    chk("rr_busy", 32'(busy), 32'(0));
    chk("rr_rspv", 32'({rsp0_valid, rsp1_valid}), 32'(0));
    chk("rr_alu",  32'({alu_a, alu_b, alu_sel, alu_shift}), 32'(0));
    chk("rr_rsp0", 32'({rsp0_result, rsp0_c, rsp0_z}), 32'(0));
    chk("rr_rsp1", 32'({rsp1_result, rsp1_c, rsp1_z}), 32'(0));
    repeat (4) @(posedge clk);
    #1;
    single_op(1'b0, r);

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
